seg_display_arbiter: RTL
========================

# seg_display_arbiter

Scan controller and arbiter for the 8-digit seven-segment display on the board. Three producers can drive the display: the CPU's `led_data` word, a latched keyboard scancode overlay, and a debug word such as the microsecond counter. The block picks one producer per refresh frame and snapshots its word so a frame never mixes two values. It then multiplexes the anodes with inter-digit blanking and optional leading-zero suppression. It runs on the 20 kHz `led_clk` domain and feeds the existing hex-to-segment decoder.

## Interface

Parameters:
- `DWELL`, default 2: `led_clk` ticks each digit's anode is held low (≥1).
- `HOLD_TICKS`, default 40000: keyboard overlay lifetime in ticks (2 s at 20 kHz); range 1..65535.

Ports:
- `led_clk`  in  1  scan clock; every rising edge is one tick.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_data`  in  32  CPU display word (owner 0).
- `kbd_data`  in  32  keyboard display word, sampled only when `kbd_req`=1.
- `kbd_req`  in  1  single-tick request: latch `kbd_data`, (re)start the overlay.
- `dbg_data`  in  32  debug display word (owner 2).
- `dbg_en`  in  1  level; debug word requested while high.
- `lz_blank`  in  1  leading-zero suppression enable, sampled at frame boundary.
- `an`  out  8  anodes, active-low, at most one bit low.
- `nibble`  out  4  hex digit for the segment decoder.
- `owner`  out  2  current frame owner: 0 CPU, 1 KBD, 2 DBG.

## Operation

- Scan FSM has two states, `SHOW` and `GAP`, plus a digit index `sel` (0..7) and a dwell counter.
  - `SHOW`: `an` = ~(1<<`sel`), or 8'hFF if digit `sel` is suppressed. `nibble` = `snap[sel*4 +: 4]`. Lasts `DWELL` ticks, then goes to `GAP`.
  - `GAP`: `an` = 8'hFF for 1 tick. `nibble` holds its value.
  - Leaving `GAP` with `sel`≠7: `sel` increments and the FSM enters `SHOW`.
  - Leaving `GAP` with `sel`=7 is the frame boundary: `sel` goes to 0 and the FSM enters `SHOW`.
- Frame boundary actions, all performed on the same edge:
  - `owner` takes the arbitration result.
  - `snap` takes the winner's word.
  - The suppression mask is recomputed from the new `snap` and `lz_blank`.
- Frame length is 8×(`DWELL`+1) ticks: 24 ticks, about 833 Hz at the defaults.
- Arbitration uses fixed priority: KBD (hold active) > DBG (`dbg_en`=1) > CPU.
- Keyboard hold:
  - On a tick with `kbd_req`=1, `kbd_latch` ← `kbd_data` and `hold_cnt` ← `HOLD_TICKS`.
  - On any other tick, `hold_cnt` decrements if nonzero.
  - Hold is active while `hold_cnt`≠0.
  - A `kbd_req` on the same tick that `hold_cnt` would reach 0 reloads the counter; reload wins.
  - Re-requests while active reload the counter and replace `kbd_latch`.
- Leading-zero suppression: digit d (1..7) is suppressed iff `lz_blank`=1 and `snap[31:d*4]`==0.
  - Digit 0 is never suppressed, so `snap`=0 shows a single "0".
- Inputs are treated as synchronous to `led_clk`. Cross-domain synchronisers belong to the producers.

## Timing

- All outputs and state are registered and change on the `led_clk` edge that performs the transition.
- Reset values:
  - FSM: state `GAP`, `sel`=7, dwell counter 0.
  - Outputs: `an`=8'hFF, `nibble`=0, `owner`=0.
  - Registers: `snap`=0, `kbd_latch`=0, `hold_cnt`=0, suppression mask 0.
- `kbd_req` is ignored while `rst`=1.
- First edge after reset release is a frame boundary. On that edge `an`=8'hFE and `nibble` = bits [3:0] of the winner's word.
- Display latency from a producer change is at most one frame plus one tick. Owner changes never occur mid-frame.
- Reset mid-frame: the next edge drives `an`=8'hFF and clears the hold. Scanning restarts at digit 0 on the first edge after release.

## Test plan

1. **Basic scan.** Reset, then `cpu_data`=0x12345678, `lz_blank`=0, `DWELL`=2. Required: `an` goes FE,FE,FF,FD,FD,FF,…,7F,7F,FF repeating every 24 ticks, with `nibble` 8,7,6,5,4,3,2,1 during the matching digits. `owner`=0.
2. **Leading-zero suppression.** `cpu_data`=0x000000A5, `lz_blank`=1. Required: only FE (nibble 5) and FD (nibble A) ever go low. Then set `cpu_data`=0: only FE goes low, with nibble 0.
3. **Tear-free snapshot.** Change `cpu_data` 0x11111111→0x22222222 while digit 3 is showing. Required: digits 3..7 of that frame still show 1. The next frame shows 2 on all digits.
4. **Keyboard overlay.** Bench `HOLD_TICKS`=100. Pulse `kbd_req` with `kbd_data`=0x1C, then change `kbd_data` to 0xFF. Required: `owner`=1 from the next frame boundary and the display shows 0x1C. `owner` returns to 0 at the first boundary after 100 ticks.
5. **Priority and retrigger.** Hold `dbg_en`=1 during the overlay. Required: `owner`=1 until the hold expires, then 2, then 0 after `dbg_en`=0. A `kbd_req` on the tick `hold_cnt`=1 extends the overlay by another 100 ticks.
6. **Reset mid-operation.** Assert `rst` while digit 4 is shown with the hold active. Required: `an`=8'hFF, `owner`=0, hold cleared. After release, the first edge gives `an`=8'hFE.

Source files
------------

// File: rtl/seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_arbiter
// Purpose  : 8-digit seven-segment scan controller with per-frame arbitration
//            between CPU, keyboard overlay and debug producers.
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_arbiter #(
    parameter int DWELL      = 2,
    parameter int HOLD_TICKS = 40000
) (
    input  logic        led_clk,
    input  logic        rst,
    input  logic [31:0] cpu_data,
    input  logic [31:0] kbd_data,
    input  logic        kbd_req,
    input  logic [31:0] dbg_data,
    input  logic        dbg_en,
    input  logic        lz_blank,
    output logic [7:0]  an,
    output logic [3:0]  nibble,
    output logic [1:0]  owner
);

    localparam int                  c_dwell_w    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [c_dwell_w-1:0] c_dwell_last = c_dwell_w'(DWELL - 1);
    localparam logic [15:0]         c_hold_ticks = 16'(HOLD_TICKS);
    localparam logic [1:0]          c_own_cpu    = 2'd0;
    localparam logic [1:0]          c_own_kbd    = 2'd1;
    localparam logic [1:0]          c_own_dbg    = 2'd2;

    typedef enum logic [0:0] {
        SHOW = 1'b0,
        GAP  = 1'b1
    } scan_state_t;

    scan_state_t          r_state;
    scan_state_t          w_state_nxt;
    logic [2:0]           r_sel;
    logic [2:0]           w_sel_nxt;
    logic [c_dwell_w-1:0] r_dwell;
    logic [c_dwell_w-1:0] w_dwell_nxt;
    logic [31:0]          r_snap;
    logic [31:0]          w_snap_nxt;
    logic [7:0]           r_lz_mask;
    logic [7:0]           w_lz_mask_nxt;
    logic [1:0]           r_owner;
    logic [1:0]           w_owner_nxt;
    logic [7:0]           r_an;
    logic [7:0]           w_an_nxt;
    logic [3:0]           r_nibble;
    logic [3:0]           w_nibble_nxt;

    logic [31:0]          r_kbd_latch;
    logic [15:0]          r_hold_cnt;
    logic                 w_hold_active;

    logic [1:0]           w_arb_owner;
    logic [31:0]          w_arb_word;
    logic [7:0]           w_arb_mask;

    // Keyboard overlay: a request always reloads, even on the expiring tick.
    always_ff @(posedge led_clk) begin
        if (rst) begin
            r_kbd_latch <= '0;
            r_hold_cnt  <= '0;
        end else if (kbd_req) begin
            r_kbd_latch <= kbd_data;
            r_hold_cnt  <= c_hold_ticks;
        end else if (r_hold_cnt != 16'd0) begin
            r_hold_cnt  <= r_hold_cnt - 16'd1;
        end
    end

    assign w_hold_active = (r_hold_cnt != 16'd0);

    always_comb begin
        w_arb_owner = c_own_cpu;
        w_arb_word  = cpu_data;
        if (w_hold_active) begin
            w_arb_owner = c_own_kbd;
            w_arb_word  = r_kbd_latch;
        end else if (dbg_en) begin
            w_arb_owner = c_own_dbg;
            w_arb_word  = dbg_data;
        end
    end

    // Digit 0 always lights so an all-zero word still shows a single "0".
    assign w_arb_mask[0] = 1'b0;
    for (genvar d = 1; d < 8; d++) begin : g_lz_mask
        assign w_arb_mask[d] = lz_blank & ~(|w_arb_word[31:4*d]);
    end

    always_ff @(posedge led_clk) begin
        if (rst) begin
            r_state   <= GAP;
            r_sel     <= 3'd7;
            r_dwell   <= '0;
            r_snap    <= '0;
            r_lz_mask <= '0;
            r_owner   <= c_own_cpu;
            r_an      <= 8'hFF;
            r_nibble  <= 4'h0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_dwell   <= w_dwell_nxt;
            r_snap    <= w_snap_nxt;
            r_lz_mask <= w_lz_mask_nxt;
            r_owner   <= w_owner_nxt;
            r_an      <= w_an_nxt;
            r_nibble  <= w_nibble_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_dwell_nxt   = r_dwell;
        w_snap_nxt    = r_snap;
        w_lz_mask_nxt = r_lz_mask;
        w_owner_nxt   = r_owner;
        w_an_nxt      = r_an;
        w_nibble_nxt  = r_nibble;

        unique case (r_state)
            SHOW: begin
                if (r_dwell == c_dwell_last) begin
                    w_state_nxt = GAP;
                    w_dwell_nxt = '0;
                    w_an_nxt    = 8'hFF;
                end else begin
                    w_dwell_nxt = r_dwell + 1'b1;
                end
            end
            GAP: begin
                w_state_nxt = SHOW;
                w_dwell_nxt = '0;
                if (r_sel == 3'd7) begin
                    // Frame boundary: new owner, snapshot and mask take effect together.
                    w_sel_nxt     = 3'd0;
                    w_snap_nxt    = w_arb_word;
                    w_lz_mask_nxt = w_arb_mask;
                    w_owner_nxt   = w_arb_owner;
                end else begin
                    w_sel_nxt     = r_sel + 3'd1;
                end
                w_an_nxt     = w_lz_mask_nxt[w_sel_nxt] ? 8'hFF : ~(8'h01 << w_sel_nxt);
                w_nibble_nxt = w_snap_nxt[{w_sel_nxt, 2'b00} +: 4];
            end
        endcase
    end

    assign an     = r_an;
    assign nibble = r_nibble;
    assign owner  = r_owner;

endmodule
`default_nettype wire
